rs232_tx_fifo: RTL and testbench

RS232 transmitter for 19200 or 115200 bps, 8N1 framing, 25 MHz clock. Accepts bytes from the CPU I/O path through a write strobe, buffers them in a small FIFO and shifts them out on TxD, LSB first. It is the transmit-side companion of the existing RS232 receiver and uses the same `fsel` rate selection and `enable` gating.

---
 rtl/rs232_tx_fifo.sv | 229 ++++++++++++++++++++++
 tb/tb_rs232_tx_fifo.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_tx_fifo.sv
`timescale 1ns/1ps
// rs232_tx_fifo
// RS232 8N1 transmitter (19200 / 115200 bps at 25 MHz) with an optional
// byte FIFO in front of the shifter. Companion of the RS232 receiver: same
// fsel rate selection and enable gating.
//
// Optional feature macro: RS232T_FIFO_EN
//   defined   : 2**DEPTH_LOG2-entry FIFO between the write strobe and the shifter
//   undefined : single-byte path, a write is accepted only while idle
//
// Ports
//   clk       in   system clock, 25 MHz
//   rst       in   asynchronous reset, active low
//   enable    in   clock enable; nothing changes on edges with enable=0
//   fsel      in   rate select, 1 = LIMIT_FAST clocks/bit, 0 = LIMIT_SLOW
//   start     in   write strobe, one enabled cycle per byte
//   data      in   byte to send
//   rdy       out  a write presented this cycle will be accepted
//   busy      out  a frame is on the line or bytes are pending
//   ovf       out  sticky: a write was presented while rdy=0
//   TxD       out  serial line, idle high, registered
//   dbg_state out  current FSM state (state_t encoding)
//
// Write handshake: on an edge with enable=1 and start=1 the byte on data is
// taken when rdy=1; when rdy=0 it is discarded and ovf is set. There is no
// back-pressure beyond rdy, so start held high for k enabled edges writes k
// bytes.
module rs232_tx_fifo #(
    parameter int LIMIT_FAST = 217,
    parameter int LIMIT_SLOW = 1302,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fsel,
    input  logic       start,
    input  logic [7:0] data,
    output logic       rdy,
    output logic       busy,
    output logic       ovf,
    output logic       TxD,
    output logic [2:0] dbg_state
);

    // S_LOAD is only used without the FIFO: it holds the freshly written
    // byte for one cycle so TxD falls one enabled edge after the write,
    // the same latency as the FIFO build.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    localparam logic [11:0] LIM_F = 12'(LIMIT_FAST);
    localparam logic [11:0] LIM_S = 12'(LIMIT_SLOW);

    state_t      state_q, state_d;
    logic [11:0] tmr_q, tmr_d;
    logic [11:0] lim_q, lim_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        txd_q, txd_d;
    logic        ovf_q, ovf_d;

    logic        bit_end;
    logic        wr_acc;
    logic        load;        // start a new frame on this edge
    logic [7:0]  load_byte;

`ifdef RS232T_FIFO_EN
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wp_q, wp_d;
    logic [DEPTH_LOG2:0] rp_q, rp_d;
    logic                fifo_empty;
    logic                fifo_full;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bit means full.
    assign fifo_empty = (wp_q == rp_q);
    assign fifo_full  = (wp_q[DEPTH_LOG2] != rp_q[DEPTH_LOG2]) &&
                        (wp_q[DEPTH_LOG2-1:0] == rp_q[DEPTH_LOG2-1:0]);

    // rdy depends only on the pre-edge fill level, so a write into a full
    // FIFO is dropped even when a pop happens on the same edge.
    assign rdy  = ~fifo_full;
    assign busy = (state_q != S_IDLE) | ~fifo_empty;

    assign wp_d = wp_q + {{DEPTH_LOG2{1'b0}}, wr_acc};
    assign rp_d = rp_q + {{DEPTH_LOG2{1'b0}}, load};

    always_ff @(posedge clk) begin
        if (enable && wr_acc) begin
            mem_q[wp_q[DEPTH_LOG2-1:0]] <= data;
        end
    end
`else
    logic unused_depth;
    assign unused_depth = ^DEPTH_LOG2;

    assign rdy  = (state_q == S_IDLE);
    assign busy = ~rdy;
`endif

    assign wr_acc  = start & rdy;
    assign bit_end = (tmr_q == lim_q - 12'd1);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        lim_d   = lim_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        ovf_d   = ovf_q | (start & ~rdy);
        load    = 1'b0;
`ifdef RS232T_FIFO_EN
        load_byte = mem_q[rp_q[DEPTH_LOG2-1:0]];
`else
        load_byte = sh_q;
`endif

        case (state_q)
            S_IDLE: begin
`ifdef RS232T_FIFO_EN
                load = ~fifo_empty;
`else
                if (wr_acc) begin
                    sh_d    = data;
                    state_d = S_LOAD;
                end
`endif
            end
`ifndef RS232T_FIFO_EN
            S_LOAD: begin
                load = 1'b1;
            end
`endif
            S_START: begin
                if (bit_end) begin
                    tmr_d   = 12'd0;
                    txd_d   = sh_q[0];
                    sh_d    = {1'b0, sh_q[7:1]};
                    bit_d   = 4'd0;
                    state_d = S_DATA;
                end else begin
                    tmr_d = tmr_q + 12'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    tmr_d = 12'd0;
                    if (bit_q == 4'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        txd_d = sh_q[0];
                        sh_d  = {1'b0, sh_q[7:1]};
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    tmr_d = tmr_q + 12'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    tmr_d   = 12'd0;
                    state_d = S_IDLE;
`ifdef RS232T_FIFO_EN
                    // Pending byte: go straight into its start bit.
                    load = ~fifo_empty;
`endif
                end else begin
                    tmr_d = tmr_q + 12'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Frame start: rate is latched here and held for the whole frame.
        if (load) begin
            sh_d    = load_byte;
            lim_d   = fsel ? LIM_F : LIM_S;
            tmr_d   = 12'd0;
            bit_d   = 4'd0;
            txd_d   = 1'b0;
            state_d = S_START;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tmr_q   <= 12'd0;
            lim_q   <= LIM_F;
            bit_q   <= 4'd0;
            sh_q    <= 8'd0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
`ifdef RS232T_FIFO_EN
            wp_q    <= '0;
            rp_q    <= '0;
`endif
        end else if (enable) begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            lim_q   <= lim_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
`ifdef RS232T_FIFO_EN
            wp_q    <= wp_d;
            rp_q    <= rp_d;
`endif
        end
    end

    assign TxD       = txd_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rs232_tx_fifo.sv
`timescale 1ns/1ps
// Testbench for rs232_tx_fifo: line-level model (byte queue + frame position)
// compared against the DUT on every falling clock edge, plus hand-computed
// frame checks.
module tb_rs232_tx_fifo;

  localparam int LF = 217;
  localparam int LS = 1302;
  localparam int DL2 = 2;
`ifdef RS232T_FIFO_EN
  localparam bit FIFO_ON = 1'b1;
  localparam int CAP = 1 << DL2;
`else
  localparam bit FIFO_ON = 1'b0;
  localparam int CAP = 1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic       fsel = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       rdy, busy, ovf, TxD;
  logic [2:0] dbg_state;

  initial forever #5 clk = ~clk;

  rs232_tx_fifo #(.LIMIT_FAST(LF), .LIMIT_SLOW(LS), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fsel(fsel), .start(start),
    .data(data), .rdy(rdy), .busy(busy), .ovf(ovf), .TxD(TxD),
    .dbg_state(dbg_state)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int en_mode = 0;  // 0: enable=1, 1: alternate, 2: random 3/4

  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(negedge clk); #2;
    case (en_mode)
      1: enable = ~enable;
      2: enable = ($urandom_range(0, 3) != 0);
      default: enable = 1'b1;
    endcase
  end

  // ---------------- behavioural model ----------------
  // Accepted bytes wait in exp_q; the frame on the line is described by its
  // byte, its bit width and how many enabled cycles of it have elapsed.
  logic [7:0] exp_q[$];
  bit         in_frame = 1'b0;
  logic [7:0] f_byte = 8'h00;
  int         f_lim = LF;
  int         f_pos = 0;
  bit         m_ovf = 1'b0;
  bit         m_rdy_pre;

  function automatic bit model_rdy();
    return (exp_q.size() < CAP) && (FIFO_ON || !in_frame);
  endfunction

  function automatic bit model_busy();
    return in_frame || (exp_q.size() > 0);
  endfunction

  function automatic bit model_txd();
    int k;
    if (!in_frame) return 1'b1;
    k = f_pos / f_lim;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return f_byte[k-1];
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      exp_q.delete();
      in_frame = 1'b0;
      f_pos = 0;
      m_ovf = 1'b0;
    end else if (enable) begin
      m_rdy_pre = model_rdy();
      if (in_frame) begin
        if (f_pos == 10 * f_lim - 1) in_frame = 1'b0;
        else f_pos++;
      end
      if (!in_frame && exp_q.size() > 0) begin
        f_byte = exp_q.pop_front();
        f_lim = fsel ? LF : LS;
        f_pos = 0;
        in_frame = 1'b1;
      end
      if (start) begin
        if (m_rdy_pre) exp_q.push_back(data);
        else m_ovf = 1'b1;
      end
    end
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      n_total++;
      if ({TxD, rdy, busy, ovf} === {model_txd(), model_rdy(), model_busy(), m_ovf})
        n_pass++;
      else
        $display("FAIL outputs cyc=%0d TxD/rdy/busy/ovf got %b%b%b%b expected %b%b%b%b",
                 cyc, TxD, rdy, busy, ovf, model_txd(), model_rdy(), model_busy(), m_ovf);
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    start = 1'b1; data = b;
    tick();
    start = 1'b0;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // Follow one frame from the call point: latency to first low, TxD sampled
  // mid-bit for 10 bits, first return high, and time from low until busy=0.
  task automatic capture(input int cpb, output logic [9:0] bits, output int lat,
                         output int low_len, output int len);
    int c0, t_low, n, target;
    bit hi_seen;
    c0 = cyc; bits = '0; lat = -1; low_len = -1; len = -1;
    n = 0;
    while (TxD !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
    if (TxD !== 1'b0) begin timeout_fail("capture_start"); return; end
    t_low = cyc; lat = t_low - c0; hi_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      target = t_low + cpb / 2 + cpb * i;
      while (cyc < target) begin
        @(negedge clk);
        if (!hi_seen && TxD === 1'b1) begin hi_seen = 1'b1; low_len = cyc - t_low; end
      end
      bits[i] = TxD;
    end
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
    if (busy !== 1'b0) begin timeout_fail("capture_busy"); return; end
    len = cyc - t_low;
  endtask

  // ---------------- main sequence ----------------
  logic [9:0] bits;
  int lat, low_len, len, k, n;

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("reset_txd", TxD, 1);
    check("reset_rdy", rdy, 1);
    check("reset_busy", busy, 0);
    check("reset_ovf", ovf, 0);

    // 0xA5 at the fast rate
    fsel = 1'b1;
    write_byte(8'hA5);
    check("busy_after_write", busy, 1);
    capture(LF, bits, lat, low_len, len);
    check("a5_latency", lat, 1);
    check("a5_bits", bits, 10'h34A);
    check("a5_start_width", low_len, 217);
    check("a5_frame_len", len, 2170);

    // 0x00 at the slow rate, fsel toggled mid-frame
    fsel = 1'b0;
    write_byte(8'h00);
    fork
      capture(LS, bits, lat, low_len, len);
      begin repeat (3000) tick(); fsel = 1'b1; repeat (5000) tick(); fsel = 1'b0; end
    join
    fsel = 1'b1;
    check("slow_latency", lat, 1);
    check("slow_bits", bits, 10'h200);
    check("slow_low_len", low_len, 9 * 1302);
    check("slow_frame_len", len, 13020);

    // six consecutive writes 0x01..0x06
    fork
      capture(LF, bits, lat, low_len, len);
      begin
        for (int i = 1; i <= 6; i++) begin start = 1'b1; data = 8'(i); tick(); end
        start = 1'b0;
      end
    join
    check("burst_latency", lat, 2);
    check("burst_first_bits", bits, 10'h202);
    check("burst_total_len", len, FIFO_ON ? 5 * 2170 : 2170);
    check("burst_ovf", ovf, 1);

    // enable at 50% duty during a frame
    write_byte(8'h3C);
    en_mode = 1;
    capture(2 * LF, bits, lat, low_len, len);
    en_mode = 0;
    tick(); tick();
    check("half_en_latency", lat, 2);
    check("half_en_bits", bits, 10'h278);
    check("half_en_low_len", low_len, 3 * 434);
    check("half_en_frame_len", len, 4340);

    // reset in the middle of a data bit, with more bytes queued behind
    write_byte(8'h5A);
    write_byte(8'h11);
    write_byte(8'h22);
    repeat (698) tick();
    check("pre_reset_txd", TxD, 0);
    #2 rst = 1'b0;
    #1;
    check("async_reset_txd", TxD, 1);
    check("async_reset_rdy", rdy, 1);
    check("async_reset_busy", busy, 0);
    check("async_reset_ovf", ovf, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    write_byte(8'h96);
    capture(LF, bits, lat, low_len, len);
    check("post_reset_latency", lat, 1);
    check("post_reset_bits", bits, 10'h32C);
    check("post_reset_frame_len", len, 2170);

    // random strobes, random enable, checked by the model every cycle
    en_mode = 2;
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(0, 2500)) tick();
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        start = 1'b1; data = 8'($urandom_range(0, 255));
        tick();
      end
      start = 1'b0;
    end
    en_mode = 0;
    n = 0;
    while (busy !== 1'b0 && n < 30000) begin tick(); n++; end
    if (busy !== 1'b0) timeout_fail("final_drain");
    tick();
    check("final_txd_idle", TxD, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
